// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  function automatic int idx_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Rotating-priority picker: first requester at or after ptr_i, wrapping.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int R  = 4,
  parameter int IW = 2
) (
  input  logic [R-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [R-1:0]  pick_o,
  output logic          valid_o
);

  always_comb begin
    int k;
    pick_o  = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = 0; i < R; i++) begin
      k = int'(ptr_i) + i;
      if (k >= R) k = k - R;
      if (!valid_o && req_i[k]) begin
        pick_o[k] = 1'b1;
        valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among R producers.
// Optional: FIFO_ARB_HALF_FULL_THROTTLE_EN limits new grants to req 0.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int R     = 4,
  parameter int BURST = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] req_data,
  output logic [R-1:0]   gnt,
  output logic           fifo_wr_en,
  output logic [N-1:0]   fifo_data_in,
  input  logic           fifo_full,
  input  logic           fifo_half_full,
  output logic           busy
);

  localparam int IW = idx_w(R);
  localparam int CW = $clog2(BURST + 1);

  arb_state_t    state_q, state_d;
  logic [R-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [R-1:0]  pick_req;
  logic [R-1:0]  pick;
  logic          pick_v;
  logic [IW-1:0] g_idx;
  logic          g_req;
  logic          beat;

`ifdef FIFO_ARB_HALF_FULL_THROTTLE_EN
  assign pick_req = fifo_half_full ?
                    (req & {{(R-1){1'b0}}, 1'b1}) : req;
`else
  logic unused_half_full;
  assign unused_half_full = fifo_half_full;
  assign pick_req = req;
`endif

  rr_priority_pick #(
    .R  (R),
    .IW (IW)
  ) u_pick (
    .req_i   (pick_req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .valid_o (pick_v)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < R; i++)
      if (gnt_q[i]) g_idx = IW'(i);
  end

  assign g_req = |(gnt_q & req);
  assign beat  = g_req & ~fifo_full;

  // Reset cycle never writes, even with a stale grant.
  assign fifo_wr_en = beat & ~rst;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < R; i++)
      fifo_data_in = fifo_data_in |
                     (req_data[i*N +: N] & {N{gnt_q[i]}});
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_v) begin
          gnt_d   = pick;
          state_d = ARB_BUSY;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (!g_req ||
            (beat && cnt_q == CW'(BURST - 1))) begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = (g_idx == IW'(R - 1)) ?
                    '0 : g_idx + 1'b1;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (R=4, N=8, BURST=2).
module tb_fifo_wr_arbiter;

  localparam int N = 8;
  localparam int R = 4;
  localparam int BURST = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   gnt;
  logic           fifo_wr_en;
  logic [N-1:0]   fifo_data_in;
  logic           fifo_full;
  logic           fifo_half_full;
  logic           busy;

  fifo_wr_arbiter #(.N(N), .R(R), .BURST(BURST)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_data_in   (fifo_data_in),
    .fifo_full      (fifo_full),
    .fifo_half_full (fifo_half_full),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [R-1:0] req;
    logic         full;
    logic [R-1:0] gnt;
    logic         wr;
    logic [N-1:0] data;
    logic         busy;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [N-1:0] pcnt [R];

  function automatic vec_t mk(logic r, logic [R-1:0] q, logic f,
                              logic [R-1:0] g, logic w,
                              logic [N-1:0] d, logic b);
    vec_t v;
    v.rst = r; v.req = q; v.full = f;
    v.gnt = g; v.wr = w; v.data = d; v.busy = b;
    return v;
  endfunction

  task automatic chk(string name, int row,
                     logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h",
               name, row, act, exp);
    end
  endtask

  // Producer i presents 8'h10*(i+1) + beats it has seen.
  task automatic drive(logic r, logic [R-1:0] q,
                       logic f, logic hf);
    @(negedge clk);
    rst = r; req = q; fifo_full = f; fifo_half_full = hf;
    for (int i = 0; i < R; i++)
      req_data[i*N +: N] = N'(8'h10 * (i + 1)) + pcnt[i];
    #1;
  endtask

  task automatic run_row(vec_t v, int row);
    drive(v.rst, v.req, v.full, 1'b0);
    chk("gnt", row, 32'(gnt), 32'(v.gnt));
    chk("wr_en", row, 32'(fifo_wr_en), 32'(v.wr));
    chk("data", row, 32'(fifo_data_in), 32'(v.data));
    chk("busy", row, 32'(busy), 32'(v.busy));
    if (v.wr)
      for (int i = 0; i < R; i++)
        if (v.gnt[i]) pcnt[i] = pcnt[i] + 1'b1;
  endtask

  initial begin
    for (int i = 0; i < R; i++) pcnt[i] = '0;
    rst = 1'b1; req = 4'hF; fifo_full = 1'b0;
    fifo_half_full = 1'b0; req_data = '0;

    // rst, req, full | gnt, wr, data, busy
    vecs.push_back(mk(1, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h1, 1, 8'h10, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h1, 1, 8'h11, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h2, 1, 8'h20, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h2, 1, 8'h21, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h4, 1, 8'h30, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h4, 1, 8'h31, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h8, 1, 8'h40, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h8, 1, 8'h41, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h1, 1, 8'h12, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h1, 1, 8'h13, 1));
    // only req[2]: granted twice in a row
    vecs.push_back(mk(0, 4'h4, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'h4, 0, 4'h4, 1, 8'h32, 1));
    vecs.push_back(mk(0, 4'h4, 0, 4'h4, 1, 8'h33, 1));
    vecs.push_back(mk(0, 4'h4, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'h4, 0, 4'h4, 1, 8'h34, 1));
    vecs.push_back(mk(0, 4'h4, 0, 4'h4, 1, 8'h35, 1));
    // req1 with 3 full cycles after first beat
    vecs.push_back(mk(0, 4'h2, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'h2, 0, 4'h2, 1, 8'h22, 1));
    vecs.push_back(mk(0, 4'h2, 1, 4'h2, 0, 8'h23, 1));
    vecs.push_back(mk(0, 4'h2, 1, 4'h2, 0, 8'h23, 1));
    vecs.push_back(mk(0, 4'h2, 1, 4'h2, 0, 8'h23, 1));
    vecs.push_back(mk(0, 4'h2, 0, 4'h2, 1, 8'h23, 1));
    // req3 drops after one beat, next grant wraps to 0
    vecs.push_back(mk(0, 4'h8, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'h8, 0, 4'h8, 1, 8'h42, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h8, 0, 8'h43, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h1, 1, 8'h14, 1));
    // reset mid-burst: no write, grant cleared
    vecs.push_back(mk(1, 4'hF, 0, 4'h1, 0, 8'h15, 1));
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 4'h1, 1, 8'h15, 1));
    // req drop while full: release, no write
    vecs.push_back(mk(0, 4'h0, 1, 4'h1, 0, 8'h16, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 0, 8'h00, 0));

    @(posedge clk);
    foreach (vecs[i]) run_row(vecs[i], i);

    // Half-full throttle sequence
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 4'hE, 1'b0, 1'b1);
    chk("hf_idle", 100, 32'(gnt), 32'h0);
`ifdef FIFO_ARB_HALF_FULL_THROTTLE_EN
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'hE, 1'b0, 1'b1);
      chk("hf_block", 101 + c, 32'(gnt), 32'h0);
    end
    drive(1'b0, 4'hF, 1'b0, 1'b1);
    chk("hf_req0_wait", 104, 32'(gnt), 32'h0);
    drive(1'b0, 4'hF, 1'b0, 1'b1);
    chk("hf_req0", 105, 32'(gnt), 32'h1);
`else
    drive(1'b0, 4'hE, 1'b0, 1'b1);
    chk("hf_ignored", 101, 32'(gnt), 32'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
